// File: rtl/mgt01_div_ctrl_pkg.sv
// rtl/mgt01_div_ctrl_pkg.sv - Shared types and constants for the divider issue controller.
package mgt01_div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_  = 2'd0,
    DIVU_ = 2'd1,
    REM_  = 2'd2,
    REMU_ = 2'd3
  } div_ops_e;

  typedef union packed {
    logic        [31:0] u;
    logic signed [31:0] s;
  } data_u;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVIDE  = 2'd1,
    SPECIAL = 2'd2,
    DONE    = 2'd3
  } div_ctrl_state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] DIV_ALL_ONES     = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input div_ops_e op);
    return (op == DIV_) || (op == REM_);
  endfunction

  function automatic logic op_is_rem(input div_ops_e op);
    return (op == REM_) || (op == REMU_);
  endfunction

endpackage

// File: rtl/mgt01_div_ctrl_if.sv
// rtl/mgt01_div_ctrl_if.sv - Request, response and divider channels of the divider controller.
interface mgt01_div_ctrl_if
  import mgt01_div_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
);
  logic             req_valid_i;
  logic             req_ready_o;
  data_u            req_dividend_i;
  data_u            req_divisor_i;
  div_ops_e         req_ops_i;
  logic [TAG_W-1:0] req_tag_i;

  logic [31:0]      div_dividend_o;
  logic [31:0]      div_divisor_o;
  div_ops_e         div_ops_o;
  logic             div_is_division_o;
  logic [31:0]      div_result_i;
  logic             div_by_zero_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_result_o;
  logic             rsp_div_by_zero_o;
  logic [TAG_W-1:0] rsp_tag_o;

  // slave is the controller; master is execute plus the divider IP
  modport slave (
    input  req_valid_i, req_dividend_i, req_divisor_i, req_ops_i, req_tag_i,
    output req_ready_o,
    output div_dividend_o, div_divisor_o, div_ops_o, div_is_division_o,
    input  div_result_i, div_by_zero_i,
    output rsp_valid_o, rsp_result_o, rsp_div_by_zero_o, rsp_tag_o,
    input  rsp_ready_i
  );

  modport master (
    output req_valid_i, req_dividend_i, req_divisor_i, req_ops_i, req_tag_i,
    input  req_ready_o,
    input  div_dividend_o, div_divisor_o, div_ops_o, div_is_division_o,
    output div_result_i, div_by_zero_i,
    input  rsp_valid_o, rsp_result_o, rsp_div_by_zero_o, rsp_tag_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/mgt01_div_special.sv
// rtl/mgt01_div_special.sv - Combinational RISC-V divide corner-case detector and result generator.
// Only built with MGT01_DIV_FAST_PATH_EN defined.
`ifdef MGT01_DIV_FAST_PATH_EN
module mgt01_div_special
  import mgt01_div_ctrl_pkg::*;
(
  input  data_u       dividend,
  input  data_u       divisor,
  input  div_ops_e    ops,
  output logic        special,
  output logic [31:0] result,
  output logic        div_by_zero
);
  always_comb begin
    special     = 1'b0;
    result      = '0;
    div_by_zero = 1'b0;
    if (divisor.u == '0) begin
      special     = 1'b1;
      div_by_zero = 1'b1;
      result      = op_is_rem(ops) ? dividend.u : DIV_ALL_ONES;
    end else if (op_is_signed(ops) && (dividend.u == DIV_OVF_DIVIDEND) &&
                 (divisor.u == DIV_ALL_ONES)) begin
      special = 1'b1;
      result  = op_is_rem(ops) ? 32'h0 : DIV_OVF_DIVIDEND;
    end
  end
endmodule
`endif

// File: rtl/mgt01_div_ctrl.sv
// rtl/mgt01_div_ctrl.sv - Issue-side controller for the multi-cycle integer divider.
// MGT01_DIV_FAST_PATH_EN resolves divide-by-zero and signed overflow without starting the divider.
module mgt01_div_ctrl
  import mgt01_div_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 34,
  parameter int TAG_W       = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clk_en_i,
  input  logic            flush_i,
  mgt01_div_ctrl_if.slave bus,
  output logic            busy_o
);
  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

  div_ctrl_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dividend_q, divisor_q, result_q;
  div_ops_e         ops_q;
  logic [TAG_W-1:0] tag_q;
  logic             dbz_q;
  logic             accept, capture, fast;

`ifdef MGT01_DIV_FAST_PATH_EN
  logic [31:0] spec_result;
  logic        spec_dbz;

  mgt01_div_special u_special (
    .dividend    (bus.req_dividend_i),
    .divisor     (bus.req_divisor_i),
    .ops         (bus.req_ops_i),
    .special     (fast),
    .result      (spec_result),
    .div_by_zero (spec_dbz)
  );
`else
  assign fast = 1'b0;
`endif

  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    accept                = 1'b0;
    capture               = 1'b0;
    bus.req_ready_o       = 1'b0;
    bus.rsp_valid_o       = 1'b0;
    bus.div_is_division_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = !flush_i;
        if (bus.req_valid_i && !flush_i && clk_en_i) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = fast ? SPECIAL : DIVIDE;
        end
      end
      DIVIDE: begin
        bus.div_is_division_o = 1'b1;
        if (clk_en_i) begin
          if (cnt_q == CNT_LAST) begin
            capture = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef MGT01_DIV_FAST_PATH_EN
      SPECIAL: begin
        if (clk_en_i) state_d = DONE;
      end
`endif
      DONE: begin
        bus.rsp_valid_o = 1'b1;
        if (clk_en_i && bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flush kills the op outright; a response handshake in the same cycle still lands in IDLE.
    if (flush_i && clk_en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      ops_q      <= DIV_;
      tag_q      <= '0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        dividend_q <= bus.req_dividend_i.u;
        divisor_q  <= bus.req_divisor_i.u;
        ops_q      <= bus.req_ops_i;
        tag_q      <= bus.req_tag_i;
`ifdef MGT01_DIV_FAST_PATH_EN
        if (fast) begin
          result_q <= spec_result;
          dbz_q    <= spec_dbz;
        end
`endif
      end
      if (capture) begin
        result_q <= bus.div_result_i;
        dbz_q    <= bus.div_by_zero_i;
      end
    end
  end

  assign bus.div_dividend_o    = dividend_q;
  assign bus.div_divisor_o     = divisor_q;
  assign bus.div_ops_o         = ops_q;
  assign bus.rsp_result_o      = result_q;
  assign bus.rsp_div_by_zero_o = dbz_q;
  assign bus.rsp_tag_o         = tag_q;
  assign busy_o                = (state_q != IDLE);

endmodule

// File: tb/tb_mgt01_div_ctrl.sv
// tb/tb_mgt01_div_ctrl.sv - Randomized self-checking bench for mgt01_div_ctrl with a divider model.
module tb_mgt01_div_ctrl;
  import mgt01_div_ctrl_pkg::*;

`ifdef MGT01_DIV_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int LAT = 34;

  logic clk = 1'b0;
  logic rst_n, clk_en, flush, busy;
  int   checks = 0;
  int   failures = 0;
  int   dcnt;

  always #5 clk = ~clk;

  mgt01_div_ctrl_if #(.TAG_W(5)) bus ();

  mgt01_div_ctrl #(.DIV_LATENCY(LAT), .TAG_W(5)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .clk_en_i (clk_en),
    .flush_i  (flush),
    .bus      (bus.slave),
    .busy_o   (busy)
  );

  // RISC-V M-extension semantics from plain arithmetic: {div_by_zero, result}
  function automatic logic [32:0] ref_div(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return {1'b1, ((op == REM_) || (op == REMU_)) ? a : 32'hFFFF_FFFF};
    case (op)
      DIV_:    return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? {1'b0, a} : {1'b0, 32'(sa / sb)};
      REM_:    return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 33'h0 : {1'b0, 32'(sa % sb)};
      DIVU_:   return {1'b0, a / b};
      default: return {1'b0, a % b};
    endcase
  endfunction

  // Divider IP model: output is garbage until LAT enabled cycles of run enable have elapsed.
  logic [32:0] div_model;
  assign div_model         = ref_div(bus.div_ops_o, bus.div_dividend_o, bus.div_divisor_o);
  assign bus.div_result_i  = (dcnt >= LAT - 1) ? div_model[31:0] : 32'hDEAD_BEEF;
  assign bus.div_by_zero_i = (dcnt >= LAT - 1) ? div_model[32] : 1'b0;

  always @(posedge clk) begin
    if (!rst_n || !bus.div_is_division_o) dcnt <= 0;
    else if (clk_en) dcnt <= dcnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, bus.req_ready_o, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
    check({tag, "_div_run"}, bus.div_is_division_o, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_div_ops"}, bus.div_ops_o, DIV_);
    check({tag, "_div_operands"}, {bus.div_dividend_o, bus.div_divisor_o}, 0);
    check({tag, "_rsp_fields"}, {bus.rsp_result_o, bus.rsp_div_by_zero_o, bus.rsp_tag_o}, 0);
  endtask

  task automatic drive_req(input div_ops_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    @(negedge clk);
    check("req_ready_idle", bus.req_ready_o, 1);
    bus.req_valid_i      = 1'b1;
    bus.req_ops_i        = op;
    bus.req_dividend_i.u = a;
    bus.req_divisor_i.u  = b;
    bus.req_tag_i        = tag;
    @(negedge clk);
    bus.req_valid_i      = 1'b0;
    bus.req_dividend_i.u = $urandom;
    bus.req_divisor_i.u  = $urandom;
  endtask

  task automatic run_op(input div_ops_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, input int stall_at);
    logic [32:0] e;
    bit special, seen_div, held_ok, rdy_ok, stable_ok;
    int n, exp_lat;
    e = ref_div(op, a, b);
    special = FAST && ((b == 32'h0) ||
              (((op == DIV_) || (op == REM_)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = special ? 2 : LAT + 1;
    if (stall_at > 0) exp_lat += 4;
    drive_req(op, a, b, tag);
    n = 1; seen_div = 0; held_ok = 1; rdy_ok = 1;
    while (!bus.rsp_valid_o && n < 200) begin
      if (bus.div_is_division_o) begin
        seen_div = 1;
        if (bus.div_dividend_o !== a || bus.div_divisor_o !== b || bus.div_ops_o !== op) held_ok = 0;
      end
      if (bus.req_ready_o !== 1'b0) rdy_ok = 0;
      if (stall_at > 0 && n == stall_at) clk_en = 1'b0;
      if (stall_at > 0 && n == stall_at + 4) clk_en = 1'b1;
      @(negedge clk);
      n++;
    end
    clk_en = 1'b1;
    check("latency", n, exp_lat);
    check("result", bus.rsp_result_o, e[31:0]);
    check("div_by_zero", bus.rsp_div_by_zero_o, e[32]);
    check("tag", bus.rsp_tag_o, tag);
    check("div_started", seen_div, !special);
    check("operands_held", held_ok, 1);
    check("req_ready_busy", rdy_ok, 1);
    stable_ok = 1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== e[31:0] ||
          bus.rsp_tag_o !== tag || bus.req_ready_o !== 1'b0) stable_ok = 0;
    end
    if (hold > 0) check("rsp_stable", stable_ok, 1);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("rsp_drop", {bus.rsp_valid_o, busy, bus.req_ready_o}, 3'b001);
  endtask

  task automatic flush_op(input div_ops_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bit seen_rsp;
    drive_req(op, a, b, tag);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_run", bus.div_is_division_o, 0);
    check("flush_idle", {busy, bus.rsp_valid_o}, 2'b00);
    seen_rsp = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen_rsp = 1;
    end
    check("flush_no_rsp", seen_rsp, 0);
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_ops_i = DIV_; bus.req_tag_i = '0;
    bus.req_dividend_i.u = '0; bus.req_divisor_i.u = '0; bus.rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    run_op(DIV_, 32'd100, 32'd5, 5'd3, 0, 0);
    run_op(REM_, 32'hFFFF_FE6E, 32'd5, 5'd7, 5, 0);
    run_op(DIV_, 32'hFFFF_FFB0, 32'd0, 5'd9, 1, 0);
    run_op(DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0);
    run_op(REM_, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 0);
    flush_op(DIVU_, 32'hFFFF_FFDF, 32'd8, 5'd20);
    run_op(DIVU_, 32'd0, 32'd8, 5'd21, 0, 0);
    run_op(DIV_, 32'd900, 32'd5, 5'd30, 0, 12);

    drive_req(DIVU_, 32'd1234, 32'd7, 5'd5);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      div_ops_e op;
      logic [31:0] a, b;
      int sel;
      op  = div_ops_e'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      a   = $urandom;
      b   = (sel == 2) ? 32'($urandom_range(1, 17)) : $urandom;
      if (sel == 0) b = 32'h0;
      if (sel == 1) begin
        a  = 32'h8000_0000;
        b  = 32'hFFFF_FFFF;
        op = ($urandom_range(0, 1) == 0) ? DIV_ : REM_;
      end
      run_op(op, a, b, 5'($urandom), $urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mgt01_div_ctrl.md
Name: mgt01_div_ctrl

Overview:
- Issue-side controller for the multi-cycle integer divider IP.
- Accepts one DIV/DIVU/REM/REMU request at a time from execute over a valid/ready handshake.
- Holds operands stable on the divider for the whole operation and counts its fixed latency.
- Returns the result with its tag over a valid/ready response channel; supports pipeline flush.

Parameters:
- DIV_LATENCY, 34, cycles (clk_en-qualified) from divider start to a valid div_result_i
- TAG_W, 5, width of the instruction/ROB tag carried with each request

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- clk_en_i  in  1  clock enable; no state, counter or handshake advances while low
- flush_i  in  1  kill any in-flight or pending operation
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request
- req_dividend_i  in  32 (data_u)  dividend
- req_divisor_i  in  32 (data_u)  divisor
- req_ops_i  in  div_ops_e  DIV_/DIVU_/REM_/REMU_
- req_tag_i  in  TAG_W  tag
- div_dividend_o, div_divisor_o  out  32  registered operands to divider
- div_ops_o  out  div_ops_e  registered op to divider
- div_is_division_o  out  1  divider run enable
- div_result_i  in  32  divider result
- div_by_zero_i  in  1  divider exception bit
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_result_o  out  32  result
- rsp_div_by_zero_o  out  1  divisor was zero
- rsp_tag_o  out  TAG_W  tag of response
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0 except req_ready_o = 1; state IDLE; counter 0; div_ops_o = DIV_.
- States: IDLE, DIVIDE, SPECIAL (fast path only), DONE.
- IDLE:
  - req_ready_o = !flush_i.
  - Accept on req_valid_i && req_ready_o && clk_en_i: register operands, op and tag.
  - Next state is DIVIDE, or SPECIAL when the fast path applies.
- DIVIDE:
  - div_is_division_o = 1; operands and op outputs held constant; counter increments each enabled cycle.
  - When counter == DIV_LATENCY - 1: capture div_result_i and div_by_zero_i into the response registers, then go to DONE.
  - Accept to rsp_valid_o = DIV_LATENCY + 1 enabled cycles.
  - div_is_division_o drops in the cycle DONE is entered.
- SPECIAL: one cycle; the computed result is registered, then DONE. Accept to rsp_valid_o = 2 cycles.
- DONE:
  - rsp_valid_o = 1; result and tag held stable until rsp_ready_i && clk_en_i, then IDLE.
  - req_ready_o = 0 in DONE, so there is no back-to-back overlap; the next accept is possible the cycle after the handshake.
- flush_i in any state: next state IDLE, counter cleared, div_is_division_o = 0 and rsp_valid_o = 0 next cycle. No response is produced for the killed op.
  - Flush in the same cycle as a response handshake: the handshake completes, then IDLE.
- rst_n_i low mid-operation: identical to the reset values on the next edge; the divider is dropped.
- clk_en_i low: freezes state, counter and outputs; handshakes are not taken.
- Signedness: DIV_/REM_ are signed, DIVU_/REMU_ unsigned. Results are exactly as produced by the divider in the non-fast path.

Optional Feature:
- Macro: MGT01_DIV_FAST_PATH_EN.
- Defined — RISC-V corner cases are resolved without starting the divider (SPECIAL state):
  - Divisor 0: DIV_/DIVU_ -> 0xFFFFFFFF; REM_/REMU_ -> dividend; rsp_div_by_zero_o = 1.
  - Signed overflow (DIV_/REM_ with 0x80000000 / 0xFFFFFFFF): DIV_ -> 0x80000000, REM_ -> 0, div_by_zero = 0.
- Undefined: every request goes through DIVIDE. rsp_div_by_zero_o comes from div_by_zero_i, and the SPECIAL state is not present.

Decomposition:
- Shared package (existing core package) holds:
  - div_ops_e, data_u
  - a new div_ctrl_state_e {IDLE, DIVIDE, SPECIAL, DONE}
  - constants DIV_OVF_DIVIDEND = 32'h8000_0000 and DIV_ALL_ONES = 32'hFFFF_FFFF
- One sub-module: mgt01_div_special, a combinational corner-case detector/result generator, instantiated only under the macro.

Test Plan:
- Reset, then DIV_ 100/5 tag 3 -> rsp_valid_o exactly 35 cycles after accept; result 20, tag 3, div_by_zero 0.
- REM_ 0xFFFFFE6E (-402)/5 with rsp_ready_i held low 5 cycles -> result 0xFFFFFFFE (-2) held stable for all 5 cycles; req_ready_o stays 0 until the handshake.
- DIV_ 0xFFFFFFB0 (-80)/0:
  - With fast path: rsp in 2 cycles, result 0xFFFFFFFF, div_by_zero 1, div_is_division_o never asserted.
  - Without fast path: rsp at 35 cycles, div_by_zero 1.
- DIV_ 0x80000000/0xFFFFFFFF (fast path) -> 0x80000000 in 2 cycles; REM_ with the same operands -> 0.
- DIVU_ 0xFFFFFFDF/8, flush_i pulsed 10 cycles after accept -> div_is_division_o = 0 next cycle, no rsp_valid_o ever; a following DIVU_ 0/8 returns 0 at 35 cycles.
- clk_en_i low for 4 cycles mid-DIVIDE on DIV_ 900/5 -> rsp_valid_o delayed exactly 4 cycles; result 180.
